// File: rtl/reg_bank_arbiter_if.sv
// Bus between the requesting pipeline stages and the shared register bank.
// Each requester raises req[i] with its address/data slice. The arbiter answers with
// a one-cycle gnt[i] on the edge that commits the write. Payload stays stable while
// req[i] is high, and the requester drops req[i] in the cycle it sees gnt[i].
interface reg_bank_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] wr_addr;
  logic [NREQ*WIDTH-1:0]  wr_data;
  logic                   set_all;
  logic                   clr_all;
  logic [ADDR_W-1:0]      rd_addr;
  logic [WIDTH-1:0]       rd_data;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic [15:0]            wr_count;

  modport master (
    output req, wr_addr, wr_data, set_all, clr_all, rd_addr,
    input  rd_data, gnt, busy, wr_count
  );

  modport slave (
    input  req, wr_addr, wr_data, set_all, clr_all, rd_addr,
    output rd_data, gnt, busy, wr_count
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a small register bank, with bank-wide
// set/clear, a combinational read port and a saturating commit counter.
module reg_bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input logic               clk,
  input logic               reset,
  reg_bank_arbiter_if.slave bus
);
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  bank [DEPTH];
  logic [PW-1:0]     ptr;
  logic [NREQ-1:0]   gnt_q;
  logic              busy_q;
  logic [15:0]       count_q;

  logic [NREQ-1:0]   cand;
  logic              found;
  logic [PW-1:0]     win;
  logic [PW:0]       sum;
  logic [PW-1:0]     idx;
  logic [ADDR_W-1:0] addr_a [NREQ];
  logic [WIDTH-1:0]  data_a [NREQ];

  // A requester whose grant is showing this cycle is excluded so a held req
  // is never committed twice.
  assign cand = bus.req & ~gnt_q;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = bus.wr_addr[i*ADDR_W +: ADDR_W];
      data_a[i] = bus.wr_data[i*WIDTH +: WIDTH];
    end
  end

  // First candidate at or after ptr, wrapping from NREQ-1 back to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) bank[a] <= '0;
      gnt_q   <= '0;
      ptr     <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      busy_q <= |cand;
      if (bus.clr_all) begin
        for (int a = 0; a < DEPTH; a++) bank[a] <= '0;
        gnt_q <= '0;
      end else if (bus.set_all) begin
        for (int a = 0; a < DEPTH; a++) bank[a] <= '1;
        gnt_q <= '0;
      end else if (found) begin
        gnt_q            <= NREQ'(1) << win;
        bank[addr_a[win]] <= data_a[win];
        ptr              <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end else begin
        gnt_q <= '0;
      end
    end
  end

  assign bus.rd_data  = bank[bus.rd_addr];
  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.wr_count = count_q;
endmodule
